// File: rtl/rom_arbiter_pkg.sv
// Shared definitions for the two-channel ROM lookup arbiter.
package rom_arb_pkg;

    // Channel tag carried alongside every in-flight lookup.
    typedef enum logic [0:0] {
        CH0 = 1'b0,
        CH1 = 1'b1
    } ch_tag_e;

    localparam int NUM_CH = 2;

endpackage : rom_arb_pkg

// File: rtl/rom_arbiter_if.sv
// Request, response and ROM-side signals of the ROM arbiter.
interface rom_arbiter_if #(
    parameter int ADDRESS_WIDTH = 8,
    parameter int DATA_WIDTH    = 8
);
    logic                     req0_valid;
    logic [ADDRESS_WIDTH-1:0] req0_addr;
    logic                     req0_ready;
    logic                     req1_valid;
    logic [ADDRESS_WIDTH-1:0] req1_addr;
    logic                     req1_ready;
    logic [ADDRESS_WIDTH-1:0] rom_addr;
    logic [DATA_WIDTH-1:0]    rom_dout;
    logic                     rsp0_valid;
    logic [DATA_WIDTH-1:0]    rsp0_data;
    logic                     rsp1_valid;
    logic [DATA_WIDTH-1:0]    rsp1_data;

    // Arbiter side.
    modport slave (
        input  req0_valid, req0_addr, req1_valid, req1_addr, rom_dout,
        output req0_ready, req1_ready, rom_addr,
        output rsp0_valid, rsp0_data, rsp1_valid, rsp1_data
    );

    // Requester / ROM side.
    modport master (
        output req0_valid, req0_addr, req1_valid, req1_addr, rom_dout,
        input  req0_ready, req1_ready, rom_addr,
        input  rsp0_valid, rsp0_data, rsp1_valid, rsp1_data
    );
endinterface : rom_arbiter_if

// File: rtl/rom_arbiter_arb.sv
// Two-way round-robin arbiter; the last-granted channel loses the next tie.
module rr_arb2
    import rom_arb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] req_valid_i,
    output logic              gnt_valid_o,
    output ch_tag_e           gnt_ch_o
);

    ch_tag_e last_grant_q;
    ch_tag_e last_grant_d;
    logic    gnt_any_s;
    ch_tag_e gnt_ch_s;

    // Pick a winner; no grant is issued while reset is held.
    always_comb begin
        gnt_any_s    = 1'b0;
        gnt_ch_s     = CH0;
        last_grant_d = last_grant_q;
        case (req_valid_i)
            2'b11: begin
                gnt_any_s = 1'b1;
                gnt_ch_s  = (last_grant_q == CH0) ? CH1 : CH0;
            end
            2'b01: begin
                gnt_any_s = 1'b1;
                gnt_ch_s  = CH0;
            end
            2'b10: begin
                gnt_any_s = 1'b1;
                gnt_ch_s  = CH1;
            end
            default: begin
                gnt_any_s = 1'b0;
                gnt_ch_s  = CH0;
            end
        endcase
        if (gnt_any_s && !rst) begin
            last_grant_d = gnt_ch_s;
        end else begin
            last_grant_d = last_grant_q;
        end
    end

    assign gnt_valid_o = gnt_any_s & ~rst;
    assign gnt_ch_o    = gnt_ch_s;

    // Remember the last winner; reset favours channel 0 on the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q <= CH1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule : rr_arb2

// File: rtl/rom_arbiter.sv
// Shares one synchronous ROM between two lookup channels; responses
// return two cycles after acceptance, tagged to the requesting channel.
module rom_arbiter
    import rom_arb_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 8,
    parameter int DATA_WIDTH    = 8
) (
    input  logic         clk,
    input  logic         rst,
    rom_arbiter_if.slave bus
);

    logic                     gnt_valid_s;
    ch_tag_e                  gnt_ch_s;
    logic [ADDRESS_WIDTH-1:0] rom_addr_q;
    logic [ADDRESS_WIDTH-1:0] rom_addr_d;
    logic                     s1_valid_q;
    ch_tag_e                  s1_tag_q;
    logic                     rsp0_valid_q;
    logic                     rsp0_valid_d;
    logic [DATA_WIDTH-1:0]    rsp0_data_q;
    logic [DATA_WIDTH-1:0]    rsp0_data_d;
    logic                     rsp1_valid_q;
    logic                     rsp1_valid_d;
    logic [DATA_WIDTH-1:0]    rsp1_data_q;
    logic [DATA_WIDTH-1:0]    rsp1_data_d;

    rr_arb2 u_arb (
        .clk         (clk),
        .rst         (rst),
        .req_valid_i ({bus.req1_valid, bus.req0_valid}),
        .gnt_valid_o (gnt_valid_s),
        .gnt_ch_o    (gnt_ch_s)
    );

    // Steer the granted address to the ROM, otherwise keep the last one driven.
    always_comb begin
        rom_addr_d = rom_addr_q;
        if (gnt_valid_s) begin
            rom_addr_d = (gnt_ch_s == CH0) ? bus.req0_addr : bus.req1_addr;
        end else begin
            rom_addr_d = rom_addr_q;
        end
    end

    assign bus.req0_ready = gnt_valid_s & (gnt_ch_s == CH0);
    assign bus.req1_ready = gnt_valid_s & (gnt_ch_s == CH1);
    assign bus.rom_addr   = rom_addr_d;

    // Route ROM data to the tagged channel; the other channel holds its data.
    always_comb begin
        rsp0_valid_d = s1_valid_q & (s1_tag_q == CH0);
        rsp1_valid_d = s1_valid_q & (s1_tag_q == CH1);
        rsp0_data_d  = rsp0_data_q;
        rsp1_data_d  = rsp1_data_q;
        if (rsp0_valid_d) begin
            rsp0_data_d = bus.rom_dout;
        end else begin
            rsp0_data_d = rsp0_data_q;
        end
        if (rsp1_valid_d) begin
            rsp1_data_d = bus.rom_dout;
        end else begin
            rsp1_data_d = rsp1_data_q;
        end
    end

    // Address hold register and stage-1 in-flight tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rom_addr_q <= {ADDRESS_WIDTH{1'b0}};
            s1_valid_q <= 1'b0;
            s1_tag_q   <= CH0;
        end else begin
            rom_addr_q <= rom_addr_d;
            s1_valid_q <= gnt_valid_s;
            s1_tag_q   <= gnt_ch_s;
        end
    end

    // Stage-2 response registers; reset drops anything still in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp0_valid_q <= 1'b0;
            rsp0_data_q  <= {DATA_WIDTH{1'b0}};
            rsp1_valid_q <= 1'b0;
            rsp1_data_q  <= {DATA_WIDTH{1'b0}};
        end else begin
            rsp0_valid_q <= rsp0_valid_d;
            rsp0_data_q  <= rsp0_data_d;
            rsp1_valid_q <= rsp1_valid_d;
            rsp1_data_q  <= rsp1_data_d;
        end
    end

    assign bus.rsp0_valid = rsp0_valid_q;
    assign bus.rsp0_data  = rsp0_data_q;
    assign bus.rsp1_valid = rsp1_valid_q;
    assign bus.rsp1_data  = rsp1_data_q;

endmodule : rom_arbiter

// File: tb/tb_rom_arbiter.sv
// Directed bench for rom_arbiter with a ROM model mem[a] = a ^ 8'hA5.
module tb_rom_arbiter;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_bad;
    int   starve_run;
    int   starve_max;
    int   ech;

    rom_arbiter_if #(.ADDRESS_WIDTH(8), .DATA_WIDTH(8)) bus ();

    rom_arbiter #(.ADDRESS_WIDTH(8), .DATA_WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM model: one-cycle synchronous read.
    always_ff @(posedge clk) begin
        bus.rom_dout <= bus.rom_addr ^ 8'hA5;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (got !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        rst = 1'b1;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        bus.req0_addr  = 8'h01;
        bus.req1_addr  = 8'h02;

        // Reset held with both requesters active.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("rst_ready0", 32'(bus.req0_ready), 32'h0);
            check_eq("rst_ready1", 32'(bus.req1_ready), 32'h0);
            check_eq("rst_rsp0_valid", 32'(bus.rsp0_valid), 32'h0);
            check_eq("rst_rsp1_valid", 32'(bus.rsp1_valid), 32'h0);
            check_eq("rst_rsp0_data", 32'(bus.rsp0_data), 32'h0);
            check_eq("rst_rsp1_data", 32'(bus.rsp1_data), 32'h0);
            tick();
        end
        rst = 1'b0;

        // Contention from the first cycle after reset: grants 0,1,0,1.
        for (int i = 0; i < 6; i++) begin
            bus.req0_valid = (i < 4);
            bus.req1_valid = (i < 4);
            @(negedge clk);
            check_eq("cont_ready0", 32'(bus.req0_ready), 32'((i < 4) && (i % 2 == 0)));
            check_eq("cont_ready1", 32'(bus.req1_ready), 32'((i < 4) && (i % 2 == 1)));
            if (i >= 2) begin
                ech = (i - 2) % 2;
                check_eq("cont_rsp0_valid", 32'(bus.rsp0_valid), 32'(ech == 0));
                check_eq("cont_rsp1_valid", 32'(bus.rsp1_valid), 32'(ech == 1));
                if (ech == 0) check_eq("cont_rsp0_data", 32'(bus.rsp0_data), 32'h0000_00A4);
                else          check_eq("cont_rsp1_data", 32'(bus.rsp1_data), 32'h0000_00A7);
            end else begin
                check_eq("cont_rsp0_idle", 32'(bus.rsp0_valid), 32'h0);
                check_eq("cont_rsp1_idle", 32'(bus.rsp1_valid), 32'h0);
            end
            tick();
        end

        // Single channel-0 lookup of 8'h10.
        bus.req0_valid = 1'b1;
        bus.req0_addr  = 8'h10;
        @(negedge clk);
        check_eq("single_ready0", 32'(bus.req0_ready), 32'h1);
        check_eq("single_ready1", 32'(bus.req1_ready), 32'h0);
        check_eq("single_rom_addr", 32'(bus.rom_addr), 32'h0000_0010);
        tick();
        bus.req0_valid = 1'b0;
        @(negedge clk);
        check_eq("single_n1_rsp0_valid", 32'(bus.rsp0_valid), 32'h0);
        check_eq("idle_rom_addr_hold", 32'(bus.rom_addr), 32'h0000_0010);
        tick();
        @(negedge clk);
        check_eq("single_rsp0_valid", 32'(bus.rsp0_valid), 32'h1);
        check_eq("single_rsp0_data", 32'(bus.rsp0_data), 32'h0000_00B5);
        check_eq("single_rsp1_valid", 32'(bus.rsp1_valid), 32'h0);
        tick();
        @(negedge clk);
        check_eq("single_rsp0_pulse", 32'(bus.rsp0_valid), 32'h0);
        check_eq("single_rsp0_hold", 32'(bus.rsp0_data), 32'h0000_00B5);
        tick();

        // Grant channel 1 at 8'h20, then reset while it is in flight.
        bus.req1_valid = 1'b1;
        bus.req1_addr  = 8'h20;
        @(negedge clk);
        check_eq("midrst_ready1", 32'(bus.req1_ready), 32'h1);
        tick();
        bus.req1_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check_eq("midrst_rsp1_in_rst", 32'(bus.rsp1_valid), 32'h0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("midrst_rsp1_valid", 32'(bus.rsp1_valid), 32'h0);
            check_eq("midrst_rsp1_data", 32'(bus.rsp1_data), 32'h0);
            tick();
        end

        // Both channels ask for 8'hFF in the same cycle.
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        bus.req0_addr  = 8'hFF;
        bus.req1_addr  = 8'hFF;
        @(negedge clk);
        check_eq("same_ready0_first", 32'(bus.req0_ready), 32'h1);
        check_eq("same_ready1_first", 32'(bus.req1_ready), 32'h0);
        check_eq("same_rom_addr", 32'(bus.rom_addr), 32'h0000_00FF);
        tick();
        bus.req0_valid = 1'b0;
        @(negedge clk);
        check_eq("same_ready1_second", 32'(bus.req1_ready), 32'h1);
        check_eq("same_ready0_second", 32'(bus.req0_ready), 32'h0);
        tick();
        bus.req1_valid = 1'b0;
        @(negedge clk);
        check_eq("same_rsp0_valid", 32'(bus.rsp0_valid), 32'h1);
        check_eq("same_rsp0_data", 32'(bus.rsp0_data), 32'h0000_005A);
        check_eq("same_rsp1_early", 32'(bus.rsp1_valid), 32'h0);
        tick();
        @(negedge clk);
        check_eq("same_rsp1_valid", 32'(bus.rsp1_valid), 32'h1);
        check_eq("same_rsp1_data", 32'(bus.rsp1_data), 32'h0000_005A);
        check_eq("same_rsp0_after", 32'(bus.rsp0_valid), 32'h0);
        tick();

        // Fairness: channel 1 always valid, channel 0 every other cycle.
        bus.req0_addr = 8'h33;
        bus.req1_addr = 8'h44;
        starve_run = 0;
        starve_max = 0;
        for (int i = 0; i < 10; i++) begin
            bus.req1_valid = (i < 8);
            bus.req0_valid = (i < 8) && (i % 2 == 0);
            @(negedge clk);
            if (i < 8) begin
                check_eq("fair_ready0", 32'(bus.req0_ready), 32'(i % 2 == 0));
                check_eq("fair_ready1", 32'(bus.req1_ready), 32'(i % 2 == 1));
                if (bus.req1_ready) starve_run = 0;
                else                starve_run = starve_run + 1;
                if (starve_run > starve_max) starve_max = starve_run;
            end
            if (i >= 2) begin
                ech = (i - 2) % 2;
                check_eq("fair_rsp0_valid", 32'(bus.rsp0_valid), 32'(ech == 0));
                check_eq("fair_rsp1_valid", 32'(bus.rsp1_valid), 32'(ech == 1));
                if (ech == 0) check_eq("fair_rsp0_data", 32'(bus.rsp0_data), 32'h0000_0096);
                else          check_eq("fair_rsp1_data", 32'(bus.rsp1_data), 32'h0000_00E1);
            end
            tick();
        end
        check_eq("fair_starve_le1", 32'(starve_max <= 1), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule : tb_rom_arbiter
